// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, the reset instruction, fetch FSM encoding
// and the pc_next result bundle.
package core_pkg;
  localparam logic [6:0]  OP_BEQ    = 7'b1100011;
  localparam logic [6:0]  OP_ARITH  = 7'b0110011;
  localparam logic [6:0]  OP_SW     = 7'b0100011;
  localparam logic [6:0]  OP_LW     = 7'b0000011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc_nxt;
    logic        misalign;
  } pc_next_t;

  // Control-decoder view of an instruction: {funct7[5], funct3, opcode}.
  function automatic logic [10:0] ctrl_of(input logic [31:0] i);
    return {i[30], i[14:12], i[6:0]};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_next.sv
// Next-pc computation for a retiring instruction: B-type immediate, branch
// target add and target alignment check. Purely combinational.
module pc_next
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [6:0]  instr_hi,   // instr[31:25]
  input  logic [11:0] instr_lo,   // instr[11:0]
  input  logic        branch,
  output pc_next_t    nxt
);
  logic [31:0] imm_b;
  logic [31:0] tgt;
  logic        take;

  assign imm_b = {{19{instr_hi[6]}}, instr_hi[6], instr_lo[7], instr_hi[5:0], instr_lo[11:8], 1'b0};
  // A Branch from control on anything that is not a beq falls through.
  assign take  = branch && (instr_lo[6:0] == OP_BEQ);
  assign tgt   = pc + imm_b;

  assign nxt.pc_nxt   = take ? tgt : pc + 32'd4;
  assign nxt.misalign = take && (tgt[1:0] != 2'b00);
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: issues a request at pc, holds the
// returned word for execute, and advances pc on retire.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic [10:0]  ctrl_field,
  output logic         instr_valid,
  output logic [31:0]  pc_out,
  input  logic         ex_done,
  input  logic         branch,
  input  logic         stall,
  output logic         fetch_err
);
  localparam int            CW      = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(IMEM_TIMEOUT - 1);

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc;
  logic [CW-1:0] wait_cnt;
  pc_next_t      nxt;
  logic          ack_hit, to_hit, retire;

  pc_next u_pc_next (
    .pc       (pc),
    .instr_hi (instr[31:25]),
    .instr_lo (instr[11:0]),
    .branch   (branch),
    .nxt      (nxt)
  );

  assign ack_hit = (state == ST_WAIT) && imem.imem_ack;
  // Ack wins over timeout on the last allowed wait cycle.
  assign to_hit  = (state == ST_WAIT) && !imem.imem_ack && (wait_cnt == TO_LAST);
  assign retire  = (state == ST_HOLD) && ex_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (!stall) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ack_hit)     state_nxt = ST_HOLD;
        else if (to_hit) state_nxt = ST_HALT;
      end
      ST_HOLD: if (ex_done) state_nxt = nxt.misalign ? ST_HALT : ST_REQ;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    unique case (state)
      ST_REQ:  imem.imem_req = !stall;
      ST_WAIT: imem.imem_req = 1'b1;
      ST_HOLD: instr_valid   = 1'b1;
      default: ;
    endcase
  end

  assign imem.imem_addr = pc;
  assign pc_out         = pc;
  assign ctrl_field     = ctrl_of(instr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= NOP_INSTR;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (retire && !nxt.misalign) pc <= nxt.pc_nxt;
      if (ack_hit) instr <= imem.imem_rdata;
      // Counter is zero on every entry to WAIT since it clears outside it.
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CW'(1) : '0;
      if (to_hit || (retire && nxt.misalign)) fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run scored against an architectural pc model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TO       = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_done = 1'b0, branch = 1'b0, stall = 1'b0;
  logic [31:0] instr, pc_out;
  logic [10:0] ctrl_field;
  logic        instr_valid, fetch_err;
  int          errors = 0;
  int          checks = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .instr(instr), .ctrl_field(ctrl_field),
    .instr_valid(instr_valid), .pc_out(pc_out), .ex_done(ex_done), .branch(branch),
    .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // B-type immediate from its field weights.
  function automatic int imm_of(input logic [31:0] w);
    return (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
  endfunction

  function automatic logic [31:0] make_beq(input int imm);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], OP_BEQ};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.imem_ack = 1'b0; ex_done = 1'b0; stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input logic [31:0] rd, input int lat, output logic [31:0] addr, output bit ok);
    int n;
    n = 0; ok = 1'b0; addr = 'x;
    while (bus.imem_req !== 1'b1 && n < 40) begin step(); n++; end
    if (bus.imem_req === 1'b1) begin
      ok = 1'b1; addr = bus.imem_addr;
      step();
      repeat (lat) step();
      bus.imem_ack = 1'b1; bus.imem_rdata = rd; step(); bus.imem_ack = 1'b0;
    end
  endtask

  task automatic retire(input logic br);
    ex_done = 1'b1; branch = br; step(); ex_done = 1'b0; branch = 1'b0;
  endtask

  task automatic test_reset();
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    #2 rst_n = 1'b0; #2;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got=%0h exp=%0h", bus.imem_addr, RESET_PC); end
    checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL rst_pc got=%0h exp=%0h", pc_out, RESET_PC); end
    checks++; if (instr !== NOP_INSTR) begin errors++; $display("FAIL rst_instr got=%0h exp=%0h", instr, NOP_INSTR); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", fetch_err); end
    step(); step();
    rst_n = 1'b1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%0h exp=0", bus.imem_req); end
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0h exp=1", bus.imem_req); end
  endtask

  task automatic test_basic();
    logic [31:0] a; bit ok;
    do_fetch(32'h0020_8033, 0, a, ok);
    checks++; if (!ok || a !== 32'h0) begin errors++; $display("FAIL basic_addr got=%0h ok=%0d exp=0", a, ok); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_hold got=%0h exp=1", instr_valid); end
    checks++; if (ctrl_field !== 11'b0_000_0110011) begin errors++; $display("FAIL basic_ctrl got=%0b exp=00000110011", ctrl_field); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL basic_pc got=%0h exp=0", pc_out); end
    checks++; if (instr !== 32'h0020_8033) begin errors++; $display("FAIL basic_instr got=%0h exp=00208033", instr); end
  endtask

  task automatic test_sequential_and_branch();
    logic [31:0] a; bit ok;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_fetch({25'h0, OP_ARITH}, k % 2, a, ok);
      checks++; if (!ok || a !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr%0d got=%0h exp=%0h", k, a, 4 * k); end
      if (k < 4) retire(1'b0);
    end
    // Overwrite the word at 0x10 instead: fetch of 0x10 is the k=4 one above.
    retire(1'b0);
    do_reset();
    for (int k = 0; k < 4; k++) begin do_fetch({25'h0, OP_ARITH}, 0, a, ok); retire(1'b0); end
    do_fetch(32'hFE00_08E3, 0, a, ok);
    checks++; if (!ok || a !== 32'h10) begin errors++; $display("FAIL beq_src got=%0h exp=10", a); end
    retire(1'b1);
    do_fetch({25'h0, OP_ARITH}, 0, a, ok);
    checks++; if (!ok || a !== 32'h0) begin errors++; $display("FAIL beq_taken got=%0h exp=0", a); end
    retire(1'b0);
    for (int k = 0; k < 3; k++) begin do_fetch({25'h0, OP_ARITH}, 0, a, ok); retire(1'b0); end
    do_fetch(32'hFE00_08E3, 0, a, ok);
    retire(1'b0);
    do_fetch({25'h0, OP_ARITH}, 0, a, ok);
    checks++; if (!ok || a !== 32'h14) begin errors++; $display("FAIL beq_fall got=%0h exp=14", a); end
  endtask

  task automatic test_timeout();
    logic [31:0] a; bit ok;
    do_reset();
    do_fetch(32'h0000_0033, TO - 1, a, ok);
    checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_last_ack valid=%0h err=%0h exp=1/0", instr_valid, fetch_err); end
    retire(1'b0);
    step();
    repeat (TO - 1) step();
    checks++; if (bus.imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_early req=%0h err=%0h exp=1/0", bus.imem_req, fetch_err); end
    step();
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err got=%0h exp=1", fetch_err); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL to_req got=%0h exp=0", bus.imem_req); end
    bus.imem_ack = 1'b1; ex_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin errors++; $display("FAIL halt_stay%0d req=%0h valid=%0h err=%0h exp=0/0/1", i, bus.imem_req, instr_valid, fetch_err); end
    end
    bus.imem_ack = 1'b0; ex_done = 1'b0;
    rst_n = 1'b0; #2;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL halt_rst got=%0h exp=0", fetch_err); end
  endtask

  task automatic test_stall();
    logic [31:0] a; bit ok;
    do_reset();
    stall = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got=%0h exp=0", i, bus.imem_req); end
      step();
    end
    stall = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL stall_issue req=%0h addr=%0h exp=1/%0h", bus.imem_req, bus.imem_addr, RESET_PC); end
    step(); stall = 1'b1; #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL stall_wait got=%0h exp=1", bus.imem_req); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0003; step(); bus.imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%0h exp=1", instr_valid); end
    retire(1'b0);
    checks++; if (bus.imem_req !== 1'b0 || pc_out !== 32'h4) begin errors++; $display("FAIL stall_after req=%0h pc=%0h exp=0/4", bus.imem_req, pc_out); end
    stall = 1'b0;
    do_fetch(32'h0000_0003, 0, a, ok);
    checks++; if (!ok || a !== 32'h4) begin errors++; $display("FAIL stall_next got=%0h exp=4", a); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a; bit ok;
    do_reset();
    do_fetch(32'h0000_0033, 0, a, ok);
    retire(1'b0);
    step();
    #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    checks++; if (pc_out !== RESET_PC || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst pc=%0h req=%0h exp=%0h/0", pc_out, bus.imem_req, RESET_PC); end
    step(); bus.imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP_INSTR) begin errors++; $display("FAIL late_ack valid=%0h instr=%0h exp=0/%0h", instr_valid, instr, NOP_INSTR); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL late_req req=%0h addr=%0h exp=1/%0h", bus.imem_req, bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_ack_outside_and_misalign();
    logic [31:0] a; bit ok;
    do_reset();
    do_fetch(32'h0020_8033, 1, a, ok);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; step(); bus.imem_ack = 1'b0;
    checks++; if (instr !== 32'h0020_8033 || instr_valid !== 1'b1) begin errors++; $display("FAIL ack_hold instr=%0h valid=%0h exp=00208033/1", instr, instr_valid); end
    stall = 1'b1;
    retire(1'b1);
    bus.imem_ack = 1'b1; step(); bus.imem_ack = 1'b0;
    checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_out !== 32'h4) begin errors++; $display("FAIL ack_req req=%0h valid=%0h pc=%0h exp=0/0/4", bus.imem_req, instr_valid, pc_out); end
    stall = 1'b0;
    do_fetch(make_beq(6), 0, a, ok);
    retire(1'b0);
    checks++; if (pc_out !== 32'h8 || fetch_err !== 1'b0) begin errors++; $display("FAIL mis_nt pc=%0h err=%0h exp=8/0", pc_out, fetch_err); end
    do_fetch(make_beq(6), 0, a, ok);
    retire(1'b1);
    checks++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || pc_out !== 32'h8) begin errors++; $display("FAIL mis_halt err=%0h req=%0h pc=%0h exp=1/0/8", fetch_err, bus.imem_req, pc_out); end
  endtask

  task automatic test_random();
    logic [31:0] w, a, exp_pc, tgt;
    logic [10:0] exp_ctrl;
    bit ok, take, br;
    int imm, lat, s, sel;
    do_reset();
    exp_pc = RESET_PC;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 4);
      w = $urandom;
      case (sel)
        0: begin
          imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
          if ($urandom_range(0, 3) != 0) imm = imm & ~32'sd2;
          w = make_beq(imm);
        end
        1: w[6:0] = OP_ARITH;
        2: w[6:0] = OP_SW;
        3: w[6:0] = OP_LW;
        default: ;
      endcase
      lat = $urandom_range(0, 4); s = $urandom_range(0, 2); br = 1'($urandom_range(0, 1));
      if (s > 0) begin
        stall = 1'b1;
        for (int j = 0; j < s; j++) begin
          step();
          checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rnd_stall%0d got=%0h exp=0", it, bus.imem_req); end
        end
        stall = 1'b0;
      end
      do_fetch(w, lat, a, ok);
      exp_ctrl = {w[30], w[14:12], w[6:0]};
      checks++; if (!ok || a !== exp_pc) begin errors++; $display("FAIL rnd_addr%0d got=%0h exp=%0h", it, a, exp_pc); end
      checks++; if (instr !== w || ctrl_field !== exp_ctrl || pc_out !== exp_pc || instr_valid !== 1'b1) begin errors++; $display("FAIL rnd_hold%0d instr=%0h ctrl=%0h pc=%0h exp=%0h/%0h/%0h", it, instr, ctrl_field, pc_out, w, exp_ctrl, exp_pc); end
      take = br && (w[6:0] == OP_BEQ);
      tgt = exp_pc + 32'(imm_of(w));
      retire(br);
      if (take && (tgt % 4 != 0)) begin
        checks++; if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || pc_out !== exp_pc) begin errors++; $display("FAIL rnd_halt%0d err=%0h req=%0h pc=%0h exp=1/0/%0h", it, fetch_err, bus.imem_req, pc_out, exp_pc); end
        do_reset();
        exp_pc = RESET_PC;
      end else begin
        exp_pc = take ? tgt : exp_pc + 32'd4;
        checks++; if (fetch_err !== 1'b0 || pc_out !== exp_pc) begin errors++; $display("FAIL rnd_next%0d err=%0h pc=%0h exp=0/%0h", it, fetch_err, pc_out, exp_pc); end
      end
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    test_reset();
    test_basic();
    test_sequential_and_branch();
    test_timeout();
    test_stall();
    test_reset_mid_wait();
    test_ack_outside_and_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_TIMEOUT, default 16, max cycles waiting for imem_ack before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory, held until ack.
REQ-006 imem_addr  output  32  word address of fetch, equals pc while imem_req high.
REQ-007 imem_ack  input  1  memory returns imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction, stable while instr_valid high.
REQ-010 ctrl_field  output  11  {instr[30], instr[14:12], instr[6:0]}, drives control decoder instruction input.
REQ-011 instr_valid  output  1  instr/ctrl_field/pc_out valid for execute.
REQ-012 pc_out  output  32  address of held instruction.
REQ-013 ex_done  input  1  execute has consumed instruction; retire this cycle.
REQ-014 branch  input  1  control Branch output, sampled only when ex_done high.
REQ-015 stall  input  1  blocks new request issue while high.
REQ-016 fetch_err  output  1  sticky error: misaligned target or memory timeout.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, HOLD, HALT; encoding in package.
REQ-018 IDLE: one cycle after reset release -> REQ (no request in IDLE).
REQ-019 REQ: if stall low, assert imem_req, imem_addr=pc, -> WAIT; if stall high, stay REQ, imem_req low.
REQ-020 WAIT: imem_req high; on imem_ack capture imem_rdata into instr, -> HOLD; ack in same cycle as entry to WAIT accepted (min fetch latency 2 cycles REQ->HOLD).
REQ-021 WAIT timeout: counter counts cycles in WAIT; at IMEM_TIMEOUT cycles without ack -> HALT, fetch_err=1.
REQ-022 imem_ack outside WAIT ignored, no state change.
REQ-023 HOLD: instr_valid=1; wait for ex_done; ex_done high -> pc updated, -> REQ.
REQ-024 Next pc on ex_done: branch=1 -> pc + imm_b; branch=0 -> pc + 4; 32-bit wrap-around, no overflow flag.
REQ-025 imm_b = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} to 32 bits.
REQ-026 branch=1 with instr[6:0] not 7'b1100011 treated as pc+4 (defensive).
REQ-027 Branch target with bits[1:0] != 0 -> HALT, fetch_err=1, pc not updated.
REQ-028 HALT: terminal; imem_req=0, instr_valid=0; exit only by reset.
REQ-029 instr_valid low in all states except HOLD; ex_done outside HOLD ignored.
REQ-030 stall has no effect in WAIT or HOLD (outstanding request completes).

Reset
REQ-031 rst_n low asynchronously: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (nop), timeout counter=0, fetch_err=0.
REQ-032 Outputs during reset: imem_req=0, instr_valid=0, imem_addr=RESET_PC, pc_out=RESET_PC.
REQ-033 Reset asserted mid-WAIT abandons request; late imem_ack after release ignored (state IDLE).

Structure
REQ-034 Shared package core_pkg: opcode constants (beq 1100011, arith 0110011, sw 0100011, lw 0000011), NOP_INSTR, fetch state enum.
REQ-035 One sub-module pc_next: combinational imm_b generation, target add, misalignment flag.
REQ-036 All sequential state in fetch_unit; pc_next has no clock.

Verification
REQ-037 Reset release, ack 1 cycle after req, rdata 32'h0020_8033 -> imem_addr 0, HOLD, ctrl_field 11'b0_000_0110011, pc_out 0.
REQ-038 Sequential: three ex_done with branch=0 -> imem_addr sequence 0,4,8,C.
REQ-039 pc=0x10, instr 32'hFE00_08E3 (beq imm -16), ex_done+branch=1 -> next imem_addr 0x0; same with branch=0 -> 0x14.
REQ-040 imem_ack withheld 16 cycles -> HALT, fetch_err=1, imem_req=0, stays until rst_n low.
REQ-041 stall high 5 cycles in REQ -> imem_req low those cycles, request issues cycle after stall drops.
REQ-042 rst_n pulsed low during WAIT, ack arrives next cycle -> ignored, state IDLE, pc=RESET_PC.
